// File: rtl/hram_cmd_bridge.sv
// hram_cmd_bridge: byte-serial command bridge to the hyper_xface HyperRAM controller.
// Assembles {cmd, NB payload bytes MSB first} frames, runs burst writes/reads through
// DEPTH-entry write/read buffers, and returns one DATA_W response per frame, MSB first.
// Ports:
//   clk_i, reset_i                   clock, synchronous active-high reset
//   rx_valid_i, rx_data_i            received byte strobe and data
//   tx_start_o, tx_data_o, tx_ready_i  byte transmit strobe/data, transmitter idle
//   rd_req_o, wr_req_o               one-cycle access requests
//   addr_o, wr_d_o, rd_num_dwords_o  access address, write data, read burst length
//   rd_d_i, rd_rdy_i, busy_i         read data/valid, controller busy
//   status_o                         {4'b0, to_err, rx_drop, wbuf_ovf, rbuf_empty_rd}
// Optional feature: define HRAM_BRIDGE_TIMEOUT_EN to discard partial frames after
// TO_CYCLES clocks without rx_valid_i (sets to_err).
module hram_cmd_bridge #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TO_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i,
  output logic              rd_req_o,
  output logic              wr_req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wr_d_o,
  output logic [5:0]        rd_num_dwords_o,
  input  logic [DATA_W-1:0] rd_d_i,
  input  logic              rd_rdy_i,
  input  logic              busy_i,
  output logic [7:0]        status_o
);
  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(NB + 1);
  localparam int unsigned NW32 = (NB + 3) / 4;
  localparam logic [AW:0]       DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [5:0]        DEPTH_6  = 6'(DEPTH);
  localparam logic [DATA_W-1:0] ERR_WORD = {NB{8'hEE}};
  localparam logic [32*NW32-1:0] DB_REP  = {NW32{32'hDEADBEEF}};
  localparam logic [DATA_W-1:0] EMPTY_WORD = DB_REP[DATA_W-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_EXEC, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_COLLECT, S_TX
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] payload_q, payload_d, resp_q, resp_d, counter_q, counter_d;
  logic [DATA_W-1:0] wr_d_q, wr_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        rd_num_q, rd_num_d, xcnt_q, xcnt_d;
  logic              seen_busy_q, seen_busy_d, tx_wait_low_q, tx_wait_low_d;
  logic              wbuf_ovf_q, wbuf_ovf_d, rbuf_empty_rd_q, rbuf_empty_rd_d;
  logic              rx_drop_q, rx_drop_d, to_err_q, to_err_d;
  logic [AW-1:0]     wb_wp_q, wb_wp_d, wb_rp_q, wb_rp_d, rb_wp_q, rb_wp_d, rb_rp_q, rb_rp_d;
  logic [AW:0]       wb_cnt_q, wb_cnt_d, rb_cnt_q, rb_cnt_d;
  logic              wb_push, wb_pop, rb_push, rb_pop, rb_flush;
  logic              tx_start, wr_req, rd_req;
  logic [DATA_W-1:0] wb_mem [DEPTH];
  logic [DATA_W-1:0] rb_mem [DEPTH];
`ifdef HRAM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0]     timer_q, timer_d;
`endif

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;         cmd_d = cmd_q;
    payload_d = payload_q; resp_d = resp_q;     counter_d = counter_q;
    wr_d_d = wr_d_q;     addr_d = addr_q;       rd_num_d = rd_num_q;
    xcnt_d = xcnt_q;     seen_busy_d = seen_busy_q; tx_wait_low_d = tx_wait_low_q;
    wbuf_ovf_d = wbuf_ovf_q; rbuf_empty_rd_d = rbuf_empty_rd_q;
    rx_drop_d = rx_drop_q; to_err_d = to_err_q;
    wb_push = 1'b0; wb_pop = 1'b0; rb_push = 1'b0; rb_pop = 1'b0; rb_flush = 1'b0;
    tx_start = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
`ifdef HRAM_BRIDGE_TIMEOUT_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      S_IDLE: if (rx_valid_i) begin
        cmd_d = rx_data_i; cnt_d = '0; payload_d = '0; state_d = S_RX;
`ifdef HRAM_BRIDGE_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      S_RX: begin
        if (rx_valid_i) begin
          payload_d = (payload_q << 8) | DATA_W'(rx_data_i);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NB - 1)) state_d = S_EXEC;
`ifdef HRAM_BRIDGE_TIMEOUT_EN
          timer_d = '0;
        end else if (timer_q == TW'(TO_CYCLES - 1)) begin
          state_d = S_IDLE; to_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      S_EXEC: begin
        state_d = S_TX; cnt_d = '0; resp_d = counter_q;
        unique case (cmd_q)
          8'h01: begin addr_d = ADDR_W'(payload_q); resp_d = payload_q; end
          8'h02: if (wb_cnt_q == DEPTH_C) begin
                   wbuf_ovf_d = 1'b1; resp_d = ERR_WORD;
                 end else begin
                   wb_push = 1'b1; resp_d = payload_q;
                 end
          8'h03: begin
                   xcnt_d = '0; resp_d = '0;
                   if (wb_cnt_q != '0) begin wr_d_d = wb_mem[wb_rp_q]; state_d = S_WR_ISSUE; end
                 end
          8'h04: if (rb_cnt_q == '0) begin
                   rbuf_empty_rd_d = 1'b1; resp_d = EMPTY_WORD;
                 end else begin
                   rb_pop = 1'b1; resp_d = rb_mem[rb_rp_q];
                 end
          8'h05: if (payload_q[5:0] == '0 || payload_q[5:0] > DEPTH_6) begin
                   resp_d = ERR_WORD;
                 end else begin
                   rb_flush = 1'b1; rd_num_d = payload_q[5:0]; state_d = S_RD_ISSUE;
                 end
          8'h06: counter_d = counter_q + 1'b1;
          8'h07: resp_d = DATA_W'(259);
          8'h08: begin
                   resp_d = DATA_W'(status_o);
                   wbuf_ovf_d = 1'b0; rbuf_empty_rd_d = 1'b0; rx_drop_d = 1'b0; to_err_d = 1'b0;
                 end
          default: ;
        endcase
      end
      S_WR_ISSUE: if (!busy_i) begin
        wr_req = 1'b1; wb_pop = 1'b1; addr_d = addr_q + ADDR_W'(2);
        xcnt_d = xcnt_q + 1'b1; seen_busy_d = 1'b0; state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (busy_i) seen_busy_d = 1'b1;
        else if (seen_busy_q) begin
          if (wb_cnt_q != '0) begin
            wr_d_d = wb_mem[wb_rp_q]; state_d = S_WR_ISSUE;
          end else begin
            resp_d = DATA_W'(xcnt_q); cnt_d = '0; state_d = S_TX;
          end
        end
      end
      S_RD_ISSUE: if (!busy_i) begin
        rd_req = 1'b1; xcnt_d = '0; state_d = S_RD_COLLECT;
      end
      S_RD_COLLECT: if (rd_rdy_i) begin
        rb_push = 1'b1; xcnt_d = xcnt_q + 1'b1;
        if (xcnt_q + 1'b1 == rd_num_q) begin
          addr_d = addr_q + ADDR_W'({rd_num_q, 1'b0});
          resp_d = DATA_W'(rd_num_q); cnt_d = '0; state_d = S_TX;
        end
      end
      S_TX: if (!tx_wait_low_q && tx_ready_i) begin
        tx_start = 1'b1; resp_d = resp_q << 8; cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NB - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_valid_i && state_q != S_IDLE && state_q != S_RX) rx_drop_d = 1'b1;
    // A byte may start only once tx_ready has dropped after the previous start.
    if (tx_start) tx_wait_low_d = 1'b1;
    else if (!tx_ready_i) tx_wait_low_d = 1'b0;

    wb_wp_d = wb_push ? ptr_inc(wb_wp_q) : wb_wp_q;
    wb_rp_d = wb_pop  ? ptr_inc(wb_rp_q) : wb_rp_q;
    wb_cnt_d = wb_push ? wb_cnt_q + 1'b1 : (wb_pop ? wb_cnt_q - 1'b1 : wb_cnt_q);
    if (rb_flush) begin
      rb_wp_d = '0; rb_rp_d = '0; rb_cnt_d = '0;
    end else begin
      rb_wp_d = rb_push ? ptr_inc(rb_wp_q) : rb_wp_q;
      rb_rp_d = rb_pop  ? ptr_inc(rb_rp_q) : rb_rp_q;
      rb_cnt_d = rb_push ? rb_cnt_q + 1'b1 : (rb_pop ? rb_cnt_q - 1'b1 : rb_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wb_push) wb_mem[wb_wp_q] <= payload_q;
    if (rb_push) rb_mem[rb_wp_q] <= rd_d_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;  cnt_q <= '0;  cmd_q <= '0;  payload_q <= '0;  resp_q <= '0;
      counter_q <= '0;    wr_d_q <= '0; addr_q <= '0; rd_num_q <= 6'd1; xcnt_q <= '0;
      seen_busy_q <= 1'b0; tx_wait_low_q <= 1'b0;
      wbuf_ovf_q <= 1'b0; rbuf_empty_rd_q <= 1'b0; rx_drop_q <= 1'b0; to_err_q <= 1'b0;
      wb_wp_q <= '0; wb_rp_q <= '0; wb_cnt_q <= '0;
      rb_wp_q <= '0; rb_rp_q <= '0; rb_cnt_q <= '0;
`ifdef HRAM_BRIDGE_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  cmd_q <= cmd_d;  payload_q <= payload_d;
      resp_q <= resp_d;    counter_q <= counter_d; wr_d_q <= wr_d_d; addr_q <= addr_d;
      rd_num_q <= rd_num_d; xcnt_q <= xcnt_d;
      seen_busy_q <= seen_busy_d; tx_wait_low_q <= tx_wait_low_d;
      wbuf_ovf_q <= wbuf_ovf_d; rbuf_empty_rd_q <= rbuf_empty_rd_d;
      rx_drop_q <= rx_drop_d; to_err_q <= to_err_d;
      wb_wp_q <= wb_wp_d; wb_rp_q <= wb_rp_d; wb_cnt_q <= wb_cnt_d;
      rb_wp_q <= rb_wp_d; rb_rp_q <= rb_rp_d; rb_cnt_q <= rb_cnt_d;
`ifdef HRAM_BRIDGE_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  // Strobes are combinational so they can respect busy_i in the same cycle;
  // gated by reset so an abandoned burst cannot emit a final request.
  assign tx_start_o      = tx_start & ~reset_i;
  assign wr_req_o        = wr_req & ~reset_i;
  assign rd_req_o        = rd_req & ~reset_i;
  assign tx_data_o       = resp_q[DATA_W-1 -: 8];
  assign addr_o          = addr_q;
  assign wr_d_o          = wr_d_q;
  assign rd_num_dwords_o = rd_num_q;
  assign status_o        = {4'b0, to_err_q, rx_drop_q, wbuf_ovf_q, rbuf_empty_rd_q};
endmodule

// File: tb/tb_hram_cmd_bridge.sv
module tb_hram_cmd_bridge;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, tx_ready = 1'b1;
  logic rd_rdy = 1'b0, busy = 1'b0;
  logic [7:0] rx_data = '0;
  logic [DW-1:0] rd_d = '0;
  logic tx_start_o, rd_req_o, wr_req_o;
  logic [7:0] tx_data_o, status_o;
  logic [31:0] addr_o;
  logic [DW-1:0] wr_d_o;
  logic [5:0] rd_num_dwords_o;

  hram_cmd_bridge #(.DATA_W(DW), .ADDR_W(32), .DEPTH(DEPTH), .TO_CYCLES(100)) dut (
    .clk_i(clk), .reset_i(reset), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready),
    .rd_req_o(rd_req_o), .wr_req_o(wr_req_o), .addr_o(addr_o), .wr_d_o(wr_d_o),
    .rd_num_dwords_o(rd_num_dwords_o), .rd_d_i(rd_d), .rd_rdy_i(rd_rdy), .busy_i(busy),
    .status_o(status_o));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, rst_epoch = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] a; int n; } rd_t;
  logic [31:0] exp_resp[$];
  wr_t exp_wr[$];
  rd_t exp_rd[$];

  // Reference model state
  logic [31:0] m_addr = '0, m_cnt = '0;
  logic [31:0] m_wq[$], m_rq[$];
  bit m_ovf, m_emp, m_drop, m_to;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] hmem[logic [31:0]];

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E37) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_cnt = '0; m_wq.delete(); m_rq.delete();
    m_ovf = 0; m_emp = 0; m_drop = 0; m_to = 0;
  endtask

  task automatic model_cmd(input logic [7:0] c, input logic [31:0] p);
    logic [31:0] e, d;
    int n;
    case (c)
      8'h01: begin m_addr = p; e = p; end
      8'h02: if (m_wq.size() == DEPTH) begin m_ovf = 1; e = 32'hEEEEEEEE; end
             else begin m_wq.push_back(p); e = p; end
      8'h03: begin
        e = 32'(m_wq.size());
        while (m_wq.size() > 0) begin
          d = m_wq.pop_front();
          exp_wr.push_back('{m_addr, d});
          ref_mem[m_addr] = d;
          m_addr += 32'd2;
        end
      end
      8'h04: if (m_rq.size() == 0) begin m_emp = 1; e = 32'hDEADBEEF; end
             else e = m_rq.pop_front();
      8'h05: begin
        n = int'(p[5:0]);
        if (n == 0 || n > DEPTH) e = 32'hEEEEEEEE;
        else begin
          m_rq.delete();
          exp_rd.push_back('{m_addr, n});
          for (int i = 0; i < n; i++) begin
            d = m_addr + 32'(2 * i);
            m_rq.push_back(ref_mem.exists(d) ? ref_mem[d] : mem_default(d));
          end
          m_addr += 32'(2 * n);
          e = 32'(n);
        end
      end
      8'h06: begin e = m_cnt; m_cnt += 32'd1; end
      8'h07: e = 32'd259;
      8'h08: begin
        e = {28'b0, m_to, m_drop, m_ovf, m_emp};
        m_to = 0; m_drop = 0; m_ovf = 0; m_emp = 0;
      end
      default: e = m_cnt;
    endcase
    exp_resp.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1 rx_valid = 1'b0;
    g = gaps ? int'($urandom_range(0, 3)) : 0;
    if (g > 0) begin repeat (g) @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] p);
    model_cmd(c, p);
    send_byte(c, 1);
    for (int i = 3; i >= 0; i--) send_byte(p[8*i +: 8], 1);
  endtask

  task automatic wait_resp();
    int k = 0;
    while (exp_resp.size() != 0 && k < 4000) begin @(posedge clk); k++; end
    tests++;
    if (exp_resp.size() != 0) begin
      fails++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", exp_resp.size());
      exp_resp.delete();
    end
    #1;
  endtask

  task automatic frame(input logic [7:0] c, input logic [31:0] p);
    send_frame(c, p);
    wait_resp();
  endtask

  // Stray byte while the response is going out must be dropped and flagged.
  task automatic frame_with_drop(input logic [7:0] c, input logic [31:0] p);
    int k = 0;
    send_frame(c, p);
    while (!tx_start_o && k < 4000) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    m_drop = 1;
    send_byte(8'h06, 0);
    wait_resp();
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    check("rst_tx_start", 32'(tx_start_o), 32'd0);
    check("rst_wr_req", 32'(wr_req_o), 32'd0);
    check("rst_rd_req", 32'(rd_req_o), 32'd0);
    check("rst_tx_data", 32'(tx_data_o), 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_wr_d", wr_d_o, 32'd0);
    check("rst_rd_num", 32'(rd_num_dwords_o), 32'd1);
    check("rst_status", 32'(status_o), 32'd0);
  endtask

  // UART transmitter: goes not-ready 1..3 cycles after a start, for 1..4 cycles.
  initial forever begin
    @(negedge clk);
    if (tx_start_o && !reset) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1 tx_ready = 1'b0;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 tx_ready = 1'b1;
    end
  end

  // HyperRAM controller model
  initial forever begin
    logic [31:0] a, d;
    int n, ep;
    @(negedge clk);
    if (!reset && wr_req_o) begin
      a = addr_o; d = wr_d_o; hmem[a] = d; ep = rst_epoch;
      @(posedge clk); #1 busy = 1'b1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 rd_rdy = 1'b1; rd_d = $urandom;
      @(posedge clk); #1 rd_rdy = 1'b0;
      @(negedge clk);
      if (!reset && ep == rst_epoch) check("wr_d_hold", wr_d_o, d);
      @(posedge clk); #1 busy = 1'b0;
    end else if (!reset && rd_req_o) begin
      a = addr_o; n = int'(rd_num_dwords_o);
      @(posedge clk); #1 busy = 1'b1;
      for (int i = 0; i < n; i++) begin
        int g;
        g = int'($urandom_range(0, 2));
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
        d = a + 32'(2 * i);
        rd_rdy = 1'b1; rd_d = hmem.exists(d) ? hmem[d] : mem_default(d);
        @(posedge clk); #1 rd_rdy = 1'b0;
      end
      busy = 1'b0;
    end
  end

  // Monitor / scoreboard
  logic [31:0] acc;
  int nbytes = 0;
  bit prev_req = 0, tx_armed = 0;
  always @(negedge clk) begin
    if (reset) begin
      nbytes = 0; prev_req = 0; tx_armed = 0;
    end else begin
      if (tx_start_o) begin
        tests++;
        if (!tx_ready || tx_armed) begin
          fails++;
          $display("FAIL tx_handshake: tx_ready=%0b armed=%0b, required ready=1 armed=0", tx_ready, tx_armed);
        end
        tx_armed = 1;
        acc = {acc[23:0], tx_data_o};
        nbytes++;
        if (nbytes == NB) begin
          nbytes = 0;
          if (exp_resp.size() == 0) check("unexpected_resp", acc, 32'hFFFFFFFF ^ acc);
          else check("response", acc, exp_resp.pop_front());
        end
      end else if (!tx_ready) tx_armed = 0;
      if ((wr_req_o || rd_req_o) && (busy || prev_req)) begin
        tests++; fails++;
        $display("FAIL req_protocol: busy=%0b prev_req=%0b, required both 0", busy, prev_req);
      end
      if (wr_req_o) begin
        if (exp_wr.size() == 0) check("unexpected_wr_req", 32'd1, 32'd0 + 32'(busy & ~busy));
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", addr_o, w.a);
          check("wr_data", wr_d_o, w.d);
        end
      end
      if (rd_req_o) begin
        if (exp_rd.size() == 0) check("unexpected_rd_req", 32'd1, 32'd0 + 32'(busy & ~busy));
        else begin
          rd_t r;
          r = exp_rd.pop_front();
          check("rd_addr", addr_o, r.a);
          check("rd_num", 32'(rd_num_dwords_o), 32'(r.n));
        end
      end
      prev_req = wr_req_o | rd_req_o;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    check_reset_vals();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Burst write
    frame(8'h01, 32'h00000100);
    frame(8'h02, 32'h11223344);
    frame(8'h02, 32'h55667788);
    frame(8'h03, 32'h0);
    check("final_addr", addr_o, 32'h00000104);

    // Burst read with fixed memory contents
    ref_mem[32'h100] = 32'hA5A5A5A5; hmem[32'h100] = 32'hA5A5A5A5;
    ref_mem[32'h102] = 32'h5A5A5A5A; hmem[32'h102] = 32'h5A5A5A5A;
    frame(8'h01, 32'h00000100);
    frame(8'h05, 32'd2);
    frame(8'h04, 32'h0);
    frame(8'h04, 32'h0);
    frame(8'h04, 32'h0);
    frame(8'h08, 32'h0);

    // Write-buffer overflow
    for (int i = 0; i < 9; i++) frame(8'h02, $urandom);
    frame(8'h08, 32'h0);
    frame(8'h08, 32'h0);
    frame(8'h03, 32'h0);

    // Illegal read lengths
    frame(8'h05, 32'd0);
    frame(8'h05, 32'd9);

    // Counter and constant
    frame(8'h06, 32'h0);
    frame(8'h06, 32'h0);
    frame(8'h06, 32'h0);
    frame(8'h07, 32'h0);

`ifdef HRAM_BRIDGE_TIMEOUT_EN
    send_byte(8'h06, 0);
    send_byte(8'h12, 0);
    repeat (101) @(posedge clk);
    #1 m_to = 1;
    frame(8'h06, 32'h0);
    frame(8'h08, 32'h0);
`endif

    // Randomised traffic
    for (int t = 0; t < 150; t++) begin
      int r;
      logic [31:0] p;
      r = int'($urandom_range(0, 9));
      p = $urandom;
      case (r)
        0: frame(8'h01, ($urandom_range(0, 3) == 0) ? p : 32'($urandom_range(0, 63)) * 32'd2);
        1, 2: frame(8'h02, p);
        3: frame(8'h03, p);
        4: frame(8'h04, p);
        5: frame(8'h05, {p[31:6], 6'($urandom_range(0, 10))});
        6: if ($urandom_range(0, 2) == 0) frame_with_drop(8'h06, p); else frame(8'h06, p);
        7: frame(8'h07, p);
        8: frame(8'h08, p);
        default: frame(8'($urandom_range(9, 255)), p);
      endcase
    end
    frame(8'h08, 32'h0);

    // Reset in the middle of a burst write
    frame(8'h01, 32'h00000200);
    for (int i = 0; i < 3; i++) frame(8'h02, $urandom);
    send_frame(8'h03, 32'h0);
    begin
      int k = 0;
      while (exp_wr.size() > 2 && k < 4000) begin @(posedge clk); k++; end
      check("mid_write_started", 32'(exp_wr.size()), 32'd2);
    end
    @(posedge clk); #1 reset = 1'b1; rst_epoch++;
    exp_resp.delete(); exp_wr.delete(); exp_rd.delete();
    model_reset();
    repeat (2) @(posedge clk);
    check_reset_vals();
    @(posedge clk); #1 reset = 1'b0;
    repeat (60) @(posedge clk); #1;
    frame(8'h06, 32'h0);
    frame(8'h04, 32'h0);
    frame(8'h08, 32'h0);
    frame(8'h08, 32'h0);

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
